// File: rtl/pipe_hazard_ctl.sv
// Global stall/flush controller for the in-order pipeline: ext_stall, redirect and
// load-use hazards tracked through a pending-load scoreboard, plus perf counters and watchdog.
module pipe_hazard_ctl #(
  parameter int NSTAGE   = 5,
  parameter int HZ_STAGE = 2,
  parameter int LOAD_LAT = 1,
  parameter int REG_BITS = 5,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ext_stall,
  input  logic                redirect,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_valid,
  input  logic                ex_is_load,
  input  logic [REG_BITS-1:0] ex_wreg,
  output logic [NSTAGE-1:0]   stall,
  output logic [NSTAGE-1:0]   flush,
  output logic                load_use_stall,
  output logic [31:0]         stall_count,
  output logic [15:0]         flush_count,
  output logic                stall_timeout
);

  localparam int SB_N = LOAD_LAT - 1;
  localparam int SB_D = (SB_N > 0) ? SB_N : 1;
  localparam logic [NSTAGE-1:0] HOLD_MASK   = NSTAGE'((1 << HZ_STAGE) - 1);
  localparam logic [NSTAGE-1:0] REDIR_MASK  = HOLD_MASK & ~NSTAGE'(1);
  localparam logic [NSTAGE-1:0] BUBBLE_MASK = NSTAGE'(1) << HZ_STAGE;
  localparam logic [15:0]       TO_LAST     = 16'(TIMEOUT - 1);

  logic [SB_D-1:0]     sbValid;
  logic [REG_BITS-1:0] sbReg [SB_D];
  logic                rsHit, rtHit, hz;
  logic [15:0]         wdCount;

  // Entry 0 holds the load that left EX most recently; it ages out after LOAD_LAT-1 moves.
  if (SB_N > 0) begin : gSb
    always_ff @(posedge clk) begin
      if (reset) begin
        sbValid <= '0;
        for (int i = 0; i < SB_D; i++) sbReg[i] <= '0;
      end else if (!ext_stall) begin
        sbValid[0] <= ex_valid & ex_is_load & (ex_wreg != '0);
        sbReg[0]   <= ex_wreg;
        for (int i = 1; i < SB_D; i++) begin
          sbValid[i] <= sbValid[i-1];
          sbReg[i]   <= sbReg[i-1];
        end
      end
    end
  end else begin : gNoSb
    assign sbValid  = '0;
    assign sbReg[0] = '0;
  end

  always_comb begin
    rsHit = 1'b0;
    rtHit = 1'b0;
    if (ex_valid && ex_is_load) begin
      if (id_rs == ex_wreg) rsHit = 1'b1;
      if (id_rt == ex_wreg) rtHit = 1'b1;
    end
    for (int i = 0; i < SB_N; i++) begin
      if (sbValid[i] && (id_rs == sbReg[i])) rsHit = 1'b1;
      if (sbValid[i] && (id_rt == sbReg[i])) rtHit = 1'b1;
    end
    hz = id_valid & ((id_uses_rs & (id_rs != '0) & rsHit) |
                     (id_uses_rt & (id_rt != '0) & rtHit));
  end

  // Priority: reset, ext_stall, redirect (ID is wrong-path, so hazard is moot), hazard.
  always_comb begin
    stall          = '0;
    flush          = '0;
    load_use_stall = 1'b0;
    if (reset) begin
      flush = '1;
    end else if (ext_stall) begin
      stall = '1;
    end else if (redirect) begin
      flush = REDIR_MASK;
    end else if (hz) begin
      stall          = HOLD_MASK;
      flush          = BUBBLE_MASK;
      load_use_stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count   <= '0;
      flush_count   <= '0;
      wdCount       <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if ((|stall) && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (redirect && !ext_stall && (flush_count != '1)) flush_count <= flush_count + 1'b1;
      if (ext_stall) begin
        if (wdCount != '1) wdCount <= wdCount + 1'b1;
        if (wdCount == TO_LAST) stall_timeout <= 1'b1;
      end else begin
        wdCount <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench: three controllers (LOAD_LAT 1..3, TIMEOUT 10) share directed stimulus;
// stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_pipe_hazard_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       ext_stall = 1'b0, redirect = 1'b0, id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_wreg = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_valid = 1'b0, ex_is_load = 1'b0;

  logic [4:0]  stallV [3];
  logic [4:0]  flushV [3];
  logic        lusV   [3];
  logic [31:0] scV    [3];
  logic [15:0] fcV    [3];
  logic        toV    [3];

  for (genvar g = 0; g < 3; g++) begin : gDut
    pipe_hazard_ctl #(.NSTAGE(5), .HZ_STAGE(2), .LOAD_LAT(g + 1), .REG_BITS(5), .TIMEOUT(10)) u (
      .clk(clk), .reset(reset), .ext_stall(ext_stall), .redirect(redirect),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_wreg(ex_wreg),
      .stall(stallV[g]), .flush(flushV[g]), .load_use_stall(lusV[g]),
      .stall_count(scV[g]), .flush_count(fcV[g]), .stall_timeout(toV[g]));
  end

  typedef struct {
    int          dut;
    string       name;
    logic [4:0]  st;
    logic [4:0]  fl;
    logic        lus;
    logic [31:0] sc;
    logic [15:0] fc;
    logic        to;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checks++;
      if (stallV[e.dut] !== e.st || flushV[e.dut] !== e.fl || lusV[e.dut] !== e.lus ||
          scV[e.dut] !== e.sc || fcV[e.dut] !== e.fc || toV[e.dut] !== e.to) begin
        errors++;
        $display("FAIL %s lat%0d: got stall=%b flush=%b lus=%b sc=%0d fc=%0d to=%b, want stall=%b flush=%b lus=%b sc=%0d fc=%0d to=%b",
                 e.name, e.dut + 1, stallV[e.dut], flushV[e.dut], lusV[e.dut], scV[e.dut], fcV[e.dut],
                 toV[e.dut], e.st, e.fl, e.lus, e.sc, e.fc, e.to);
      end
    end
  end

  task automatic ex(input int d, input string n, input logic [4:0] st, input logic [4:0] fl,
                    input logic lus, input logic [31:0] sc, input logic [15:0] fc, input logic to);
    exp_t e;
    e.dut = d; e.name = n; e.st = st; e.fl = fl; e.lus = lus; e.sc = sc; e.fc = fc; e.to = to;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic es, input logic rd, input logic idv, input logic [4:0] a,
                     input logic [4:0] b, input logic ua, input logic ub, input logic exv,
                     input logic exl, input logic [4:0] w);
    ext_stall = es; redirect = rd; id_valid = idv; id_rs = a; id_rt = b;
    id_uses_rs = ua; id_uses_rt = ub; ex_valid = exv; ex_is_load = exl; ex_wreg = w;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state and release
    tick();
    for (int d = 0; d < 3; d++) ex(d, "in_reset", 5'b00000, 5'b11111, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    for (int d = 0; d < 3; d++) ex(d, "post_reset", 5'b00000, 5'b00000, 0, 0, 0, 0);

    // Load r8 in EX, ID reads r8: 1/2/3 hazard cycles for LOAD_LAT 1/2/3
    tick(); drv(0, 0, 1, 8, 0, 1, 0, 1, 1, 8);
    for (int d = 0; d < 3; d++) ex(d, "lu_ex", 5'b00011, 5'b00100, 1, 0, 0, 0);
    tick(); drv(0, 0, 1, 8, 0, 1, 0, 0, 0, 0);
    ex(0, "lu_c2", 5'b00000, 5'b00000, 0, 1, 0, 0);
    ex(1, "lu_c2", 5'b00011, 5'b00100, 1, 1, 0, 0);
    ex(2, "lu_c2", 5'b00011, 5'b00100, 1, 1, 0, 0);
    tick();
    ex(0, "lu_c3", 5'b00000, 5'b00000, 0, 1, 0, 0);
    ex(1, "lu_c3", 5'b00000, 5'b00000, 0, 2, 0, 0);
    ex(2, "lu_c3", 5'b00011, 5'b00100, 1, 2, 0, 0);
    tick();
    ex(1, "lu_c4", 5'b00000, 5'b00000, 0, 2, 0, 0);
    ex(2, "lu_c4", 5'b00000, 5'b00000, 0, 3, 0, 0);

    // r0 never hazards; unused rt ignored; rt path through scoreboard
    tick(); doReset();
    tick(); drv(0, 0, 1, 0, 0, 1, 1, 1, 1, 0);
    ex(2, "r0_ex", 5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); drv(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    ex(2, "r0_sb", 5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); drv(0, 0, 1, 3, 5, 1, 0, 1, 1, 5);
    ex(2, "rt_unused", 5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); drv(0, 0, 1, 3, 5, 1, 1, 0, 0, 0);
    ex(0, "rt_sb", 5'b00000, 5'b00000, 0, 0, 0, 0);
    ex(1, "rt_sb", 5'b00011, 5'b00100, 1, 0, 0, 0);
    ex(2, "rt_sb", 5'b00011, 5'b00100, 1, 0, 0, 0);
    tick(); idle();
    ex(2, "rt_after", 5'b00000, 5'b00000, 0, 1, 0, 0);

    // Redirect suppresses hazard; pending load still tracked afterwards
    tick(); doReset();
    tick(); drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
    ex(2, "rd_load", 5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); drv(0, 1, 1, 7, 0, 1, 0, 1, 0, 2);
    for (int d = 0; d < 3; d++) ex(d, "rd_hz", 5'b00000, 5'b00010, 0, 0, 0, 0);
    tick(); drv(0, 0, 1, 7, 0, 1, 0, 0, 0, 0);
    ex(1, "rd_next", 5'b00000, 5'b00000, 0, 0, 1, 0);
    ex(2, "rd_next", 5'b00011, 5'b00100, 1, 0, 1, 0);
    tick(); idle();
    ex(2, "rd_after", 5'b00000, 5'b00000, 0, 1, 1, 0);

    // ext_stall freezes a pending LOAD_LAT=2 load; redirect under ext_stall ignored
    tick(); doReset();
    tick(); drv(0, 0, 1, 9, 0, 1, 0, 1, 1, 9);
    ex(1, "es_hz", 5'b00011, 5'b00100, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(); drv(1, (k == 2), 1, 9, 0, 1, 0, 0, 0, 0);
      ex(1, "es_hold", 5'b11111, 5'b00000, 0, 32'(k), 0, 0);
    end
    tick(); drv(0, 0, 1, 9, 0, 1, 0, 0, 0, 0);
    ex(1, "es_resume", 5'b00011, 5'b00100, 1, 5, 0, 0);
    tick(); idle();
    ex(1, "es_after", 5'b00000, 5'b00000, 0, 6, 0, 0);

    // Watchdog: 9 cycles no trip, 10 cycles trips and sticks
    tick(); doReset();
    for (int k = 0; k < 9; k++) begin tick(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); end
    tick(); idle();
    ex(0, "to_9", 5'b00000, 5'b00000, 0, 9, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (k == 9) ex(0, "to_pre", 5'b11111, 5'b00000, 0, 18, 0, 0);
    end
    tick(); idle();
    ex(0, "to_set", 5'b00000, 5'b00000, 0, 19, 0, 1);
    tick();
    ex(0, "to_sticky", 5'b00000, 5'b00000, 0, 19, 0, 1);

    // Reset clears timeout; reset mid-hazard leaves no residual stall
    tick(); doReset();
    ex(0, "to_clr", 5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); drv(0, 0, 1, 4, 0, 1, 0, 1, 1, 4);
    ex(2, "mid_hz", 5'b00011, 5'b00100, 1, 0, 0, 0);
    tick(); reset = 1'b1; drv(0, 0, 1, 4, 0, 1, 0, 0, 0, 0);
    ex(2, "mid_rst", 5'b00000, 5'b11111, 0, 1, 0, 0);
    tick(); reset = 1'b0;
    ex(2, "mid_after", 5'b00000, 5'b00000, 0, 0, 0, 0);

    tick(); idle();
    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending checks, want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
